multdiv_ctrl: RTL and testbench

//  Sequential signed 32-bit multiply/divide unit shared by the execute stage.

---
 rtl/multdiv_ctrl_pkg.sv | 17 +
 rtl/multdiv_ctrl_if.sv | 28 ++
 rtl/multdiv_ctrl_addsub_unit.sv | 19 +
 rtl/multdiv_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the sequential multiply/divide unit: state and op encodings,
// default datapath width.
package multdiv_ctrl_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  typedef enum logic {
    OpMult = 1'b0,
    OpDiv  = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage <-> multiply/divide unit interface. The pipeline side is the master,
// the unit is the slave.
interface multdiv_ctrl_if
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_ctrl_addsub_unit.sv
// The single adder/subtractor shared by the Booth step and the restoring-divide trial
// subtract. carry_o is the unsigned carry-out (no borrow when subtracting).
module addsub_unit #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);

  logic [Width:0] full;

  assign full    = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{Width{1'b0}}, sub_i};
  assign sum_o   = full[Width-1:0];
  assign carry_o = full[Width];

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// One iteration per cycle over a shared adder; registered result with a one-cycle ready pulse.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic           clock,
  input logic           reset,
  multdiv_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  op_e              op_q, op_d;
  // acc_q: Booth high half (one guard bit) or divide partial remainder.
  // lo_q:  Booth multiplier / product low half, or dividend shifting into quotient.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             start;
  logic [WIDTH-1:0] opa_mag, opb_mag;
  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   as_a, as_b, as_sum;
  logic             as_sub, as_carry;
  logic [WIDTH:0]   booth_acc;
  logic             mult_ovf;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] fix_result;
  logic             fix_exc;

  assign start = (bus.ctrl_MULT | bus.ctrl_DIV) & ((state_q == StIdle) | (state_q == StDone));

  assign opa_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign opb_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  assign shifted_rem = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};

  always_comb begin
    if (op_q == OpMult) begin
      as_a   = acc_q;
      as_b   = {opb_q[WIDTH-1], opb_q};
      as_sub = lo_q[0] & ~qm1_q;
    end else begin
      as_a   = shifted_rem;
      as_b   = {1'b0, opb_q};
      as_sub = 1'b1;
    end
  end

  addsub_unit #(
    .Width (WIDTH + 1)
  ) u_addsub (
    .a_i     (as_a),
    .b_i     (as_b),
    .sub_i   (as_sub),
    .sum_o   (as_sum),
    .carry_o (as_carry)
  );

  // Booth pair {q0, q-1}: 01 adds, 10 subtracts, 00/11 leave the accumulator alone.
  assign booth_acc = (lo_q[0] ^ qm1_q) ? as_sum : acc_q;

  assign mult_ovf   = acc_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}};
  assign quot       = neg_q ? -lo_q : lo_q;
  assign fix_result = (op_q == OpMult) ? lo_q : (dbz_q ? '0 : quot);
  // A positive quotient with the top bit set can only be INT_MIN / -1.
  assign fix_exc    = (op_q == OpMult) ? mult_ovf : (dbz_q | (~neg_q & lo_q[WIDTH-1]));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A start taken in DONE abandons the pending ready pulse.
  assign rdy_d = (state_q == StDone) & ~start;

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (start) begin
      cnt_d = '0;
      acc_d = '0;
      qm1_d = 1'b0;
      neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dbz_d = bus.data_operandB == '0;
      if (bus.ctrl_MULT) begin
        op_d  = OpMult;
        lo_d  = bus.data_operandB;
        opb_d = bus.data_operandA;
      end else begin
        op_d  = OpDiv;
        lo_d  = opa_mag;
        opb_d = opb_mag;
      end
    end else if (state_q == StRun) begin
      cnt_d = cnt_q + CntW'(1);
      if (op_q == OpMult) begin
        acc_d = {booth_acc[WIDTH], booth_acc[WIDTH:1]};
        lo_d  = {booth_acc[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
      end else begin
        acc_d = as_carry ? as_sum : shifted_rem;
        lo_d  = {lo_q[WIDTH-2:0], as_carry};
      end
    end else if (state_q == StFix) begin
      result_d = fix_result;
      exc_d    = fix_exc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMult;
      acc_q    <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == StRun) | (state_q == StFix);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed corner cases plus random ops against an
// integer-arithmetic reference model.
module tb_multdiv_ctrl;

  localparam int Latency = 34;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic rdy_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multdiv_ctrl_if #(.WIDTH(32)) bus ();

  multdiv_ctrl #(
    .WIDTH (32)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic.
  function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    longint p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.start = 0;
    if (m) begin
      p     = sa * sbv;
      e.res = p[31:0];
      e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else begin
      p     = sa / sbv;
      e.res = p[31:0];
      e.exc = p > 64'sd2147483647;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    e       = model(m, a, b);
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 200; i++) begin
      if (bus.data_resultRDY) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL rdy_timeout: no ready pulse within 200 cycles (cycle %0d)", cyc);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       begin v = $urandom_range(0, 200); v = v - 32'd100; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding op, on time, one cycle wide.
  always @(negedge clk) begin
    if (!rst && bus.data_resultRDY) begin
      if (rdy_prev) begin
        checks++;
        errors++;
        $display("FAIL rdy_width: ready high for more than one cycle (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rdy: ready with no outstanding op (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", bus.data_result, mon_e.res);
        check("exception", {31'd0, bus.data_exception}, {31'd0, mon_e.exc});
        check("latency", 32'(cyc), 32'(mon_e.start + Latency));
      end
    end
    rdy_prev = bus.data_resultRDY;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    logic m;
    rst               = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", {31'd0, bus.data_exception}, 32'd0);
    check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 7 * -3, counting busy cycles up to the ready pulse.
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.data_resultRDY) break;
      if (bus.busy) busy_n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_n), 32'd33);
    check("mult_7x-3", bus.data_result, 32'hFFFF_FFEB);

    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000); wait_rdy();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);         wait_rdy();
    issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);         wait_rdy();
    issue(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);       wait_rdy();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_rdy();
    issue(1'b0, 1'b1, 32'd5, 32'd0);                 wait_rdy();
    repeat (5) @(negedge clk);
    check("hold_result", bus.data_result, 32'd0);
    check("hold_exc", {31'd0, bus.data_exception}, 32'd1);

    // Start pulse during RUN is ignored.
    issue(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd5;
    @(negedge clk);
    bus.ctrl_DIV = 1'b0;
    wait_rdy();
    check("mult_6x7_direct", bus.data_result, 32'd42);

    // Reset mid-operation abandons the op.
    issue(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midreset_result", bus.data_result, 32'd0);
    check("midreset_exc", {31'd0, bus.data_exception}, 32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    repeat (40) @(negedge clk);
    issue(1'b1, 1'b0, 32'd2, 32'd3); wait_rdy();

    // Both starts together: multiply wins; then a divide issued in the ready cycle.
    issue(1'b1, 1'b1, 32'd4, 32'd2); wait_rdy();
    issue(1'b0, 1'b1, 32'd9, 32'd3); wait_rdy();
    check("b2b_div_9_3", bus.data_result, 32'd3);

    for (int n = 0; n < 40; n++) begin
      m = 1'($urandom_range(0, 1));
      issue(m, ~m, pick(), pick());
      wait_rdy();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
